spi_xfer_ctrl: RTL

- Transfer sequencer and SCLK generator for the spi_shift datapath. It sits between the Wishbone register file and spi_shift.
- Accepts a GO request and drives tip to spi_shift.
- Generates sclk and one-cycle edge strobes (cpol_1 = rising, cpol_0 = falling), which spi_shift consumes as its shift enables.
- Drives the slave-select pads and raises a completion interrupt.

---
 rtl/spi_xfer_ctrl_pkg.sv | 23 ++
 rtl/spi_sclk_gen.sv | 71 +++++++
 rtl/spi_xfer_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_ctrl_pkg
// Description : Shared sizing constants and FSM state encoding for the SPI
//               transfer controller and its SCLK generator.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_xfer_ctrl_pkg;

    // Default width of the clock divider register
    localparam int SPI_DIVIDER_LEN = 16;
    // Default number of slave-select lines
    localparam int SPI_SS_NB       = 8;

    typedef enum logic [1:0] {
        SPI_ST_IDLE  = 2'd0,
        SPI_ST_SETUP = 2'd1,
        SPI_ST_SHIFT = 2'd2,
        SPI_ST_HOLD  = 2'd3
    } spi_state_t;

endpackage : spi_xfer_ctrl_pkg
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_sclk_gen
// Description : Half-period down-counter, SCLK toggle flop and edge-strobe
//               decode for the SPI transfer controller.
// Revision    : 1.0 - initial release
//
// Ports
//   wb_clk, wb_reset_n : clock / asynchronous active-low reset
//   div_val            : half-period minus one, loaded into the counter
//   cnt_load           : load div_val (transfer start)
//   cnt_en             : counter decrements towards zero while set
//   shift_en           : SHIFT phase; enables strobes and auto-reload
//   stop               : suppress the next rising edge (transfer ending)
//   cnt_zero           : counter is zero
//   sclk               : SPI clock, idles low
//   cpol_1 / cpol_0    : one-cycle strobes preceding sclk rise / fall
// ============================================================================
module spi_sclk_gen
    import spi_xfer_ctrl_pkg::*;
#(
    parameter int DIV_W = SPI_DIVIDER_LEN
) (
    input  logic             wb_clk,
    input  logic             wb_reset_n,
    input  logic [DIV_W-1:0] div_val,
    input  logic             cnt_load,
    input  logic             cnt_en,
    input  logic             shift_en,
    input  logic             stop,
    output logic             cnt_zero,
    output logic             sclk,
    output logic             cpol_1,
    output logic             cpol_0
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_sclk;

    assign cnt_zero = (r_cnt == '0);
    assign sclk     = r_sclk;

    // A strobe marks the last cycle of a half-period; the toggle lands on
    // the following cycle, so the strobe always precedes the sclk edge.
    assign cpol_1 = shift_en & cnt_zero & ~r_sclk & ~stop;
    assign cpol_0 = shift_en & cnt_zero &  r_sclk;

    always_ff @(posedge wb_clk or negedge wb_reset_n) begin
        if (!wb_reset_n) begin
            r_cnt <= '0;
        end else if (cnt_load || (shift_en && cnt_zero)) begin
            // Every SHIFT half-period boundary reloads, including the final
            // idle-low one that hands over to HOLD.
            r_cnt <= div_val;
        end else if (cnt_en && !cnt_zero) begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    always_ff @(posedge wb_clk or negedge wb_reset_n) begin
        if (!wb_reset_n) begin
            r_sclk <= 1'b0;
        end else if (cpol_1) begin
            r_sclk <= 1'b1;
        end else if (cpol_0 || !shift_en) begin
            r_sclk <= 1'b0;
        end
    end

endmodule : spi_sclk_gen
`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_ctrl
// Description : SPI transfer sequencer. Accepts GO, drives tip to the shift
//               datapath, generates SCLK and edge strobes via spi_sclk_gen,
//               drives slave-select pads and the completion interrupt.
// Revision    : 1.0 - initial release
//
// Ports
//   wb_clk, wb_reset_n : clock / asynchronous active-low reset
//   go_set             : one-cycle GO request
//   divider            : half-period minus one, in wb_clk cycles
//   ss_sel             : slave-select register, active-high per line
//   ass                : automatic slave select enable
//   ie                 : interrupt enable
//   irq_clr            : one-cycle interrupt clear
//   last               : character counter is zero (from spi_shift)
//   tip                : transfer in progress
//   sclk               : SPI clock, idles low
//   cpol_1 / cpol_0    : strobes preceding sclk rise / fall
//   ss_pad_o           : slave-select pads, active-low
//   irq                : completion interrupt, level
// ============================================================================
module spi_xfer_ctrl
    import spi_xfer_ctrl_pkg::*;
#(
    parameter int DIV_W = SPI_DIVIDER_LEN,
    parameter int SS_NB = SPI_SS_NB
) (
    input  logic             wb_clk,
    input  logic             wb_reset_n,
    input  logic             go_set,
    input  logic [DIV_W-1:0] divider,
    input  logic [SS_NB-1:0] ss_sel,
    input  logic             ass,
    input  logic             ie,
    input  logic             irq_clr,
    input  logic             last,
    output logic             tip,
    output logic             sclk,
    output logic             cpol_1,
    output logic             cpol_0,
    output logic [SS_NB-1:0] ss_pad_o,
    output logic             irq
);

    spi_state_t       r_state;
    logic [DIV_W-1:0] r_div_q;
    logic             r_tip;
    logic             r_edge_seen;
    logic             r_irq;
    logic [SS_NB-1:0] r_ss;

    logic             w_go_acc;
    logic             w_cnt_zero;
    logic             w_sclk;
    logic             w_cpol_1;
    logic             w_cpol_0;
    logic             w_stop;
    logic             w_done;
    logic             w_tip_nxt;
    logic [DIV_W-1:0] w_div_sel;

    assign w_go_acc  = go_set && (r_state == SPI_ST_IDLE);
    // last may already read zero at start (len=0 means maximum length),
    // so it only counts once a rising edge has been issued.
    assign w_stop    = last && r_edge_seen;
    assign w_done    = (r_state == SPI_ST_HOLD) && w_cnt_zero;
    assign w_tip_nxt = (r_state == SPI_ST_IDLE) ? go_set : !w_done;
    // The start-of-transfer load takes the live register; reloads use the
    // value captured at GO so mid-transfer writes have no effect.
    assign w_div_sel = w_go_acc ? divider : r_div_q;

    spi_sclk_gen #(
        .DIV_W (DIV_W)
    ) u_sclk_gen (
        .wb_clk     (wb_clk),
        .wb_reset_n (wb_reset_n),
        .div_val    (w_div_sel),
        .cnt_load   (w_go_acc),
        .cnt_en     (r_state != SPI_ST_IDLE),
        .shift_en   (r_state == SPI_ST_SHIFT),
        .stop       (w_stop),
        .cnt_zero   (w_cnt_zero),
        .sclk       (w_sclk),
        .cpol_1     (w_cpol_1),
        .cpol_0     (w_cpol_0)
    );

    always_ff @(posedge wb_clk or negedge wb_reset_n) begin
        if (!wb_reset_n) begin
            r_state     <= SPI_ST_IDLE;
            r_div_q     <= '0;
            r_tip       <= 1'b0;
            r_edge_seen <= 1'b0;
        end else begin
            r_tip <= w_tip_nxt;
            unique case (r_state)
                SPI_ST_IDLE: begin
                    if (go_set) begin
                        r_div_q     <= divider;
                        r_edge_seen <= 1'b0;
                        r_state     <= SPI_ST_SETUP;
                    end
                end
                SPI_ST_SETUP: begin
                    if (w_cnt_zero) begin
                        r_state <= SPI_ST_SHIFT;
                    end
                end
                SPI_ST_SHIFT: begin
                    if (w_cpol_1) begin
                        r_edge_seen <= 1'b1;
                    end
                    // Leave only from an idle-low half-period boundary.
                    if (w_cnt_zero && !w_sclk && w_stop) begin
                        r_state <= SPI_ST_HOLD;
                    end
                end
                SPI_ST_HOLD: begin
                    if (w_cnt_zero) begin
                        r_state <= SPI_ST_IDLE;
                    end
                end
                default: r_state <= SPI_ST_IDLE;
            endcase
        end
    end

    // Set has priority over clear.
    always_ff @(posedge wb_clk or negedge wb_reset_n) begin
        if (!wb_reset_n) begin
            r_irq <= 1'b0;
        end else if (w_done && ie) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    // Uses next-cycle tip so the pads switch in the same cycle as tip.
    always_ff @(posedge wb_clk or negedge wb_reset_n) begin
        if (!wb_reset_n) begin
            r_ss <= {SS_NB{1'b1}};
        end else if (ass && !w_tip_nxt) begin
            r_ss <= {SS_NB{1'b1}};
        end else begin
            r_ss <= ~ss_sel;
        end
    end

    assign tip      = r_tip;
    assign sclk     = w_sclk;
    assign cpol_1   = w_cpol_1;
    assign cpol_0   = w_cpol_0;
    assign ss_pad_o = r_ss;
    assign irq      = r_irq;

endmodule : spi_xfer_ctrl
`default_nettype wire
